// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows an external ALU
// for accumulation (add) and multiplicand shifting (shift-left by one).
module alu_mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic              ovf,
  output logic              zero,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic              alu_Cin,
  output logic [2:0]        alu_Op,
  output logic              alu_invA,
  output logic              alu_invB,
  output logic              alu_sign,
  input  logic [DATA_W-1:0] alu_Out,
  input  logic              alu_Ofl,
  input  logic              alu_Z
);

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [3:0] LAST   = 4'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHL, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [3:0]        count;
  logic              lost;
  logic              unused;

  assign unused   = alu_Z;
  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;
  assign busy     = (state == ADD) || (state == SHL);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    alu_A     = '0;
    alu_B     = '0;
    alu_Op    = OP_ADD;
    case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        alu_A     = acc;
        alu_B     = mcand;
        state_nxt = (count == LAST) ? DONE : SHL;
      end
      SHL: begin
        alu_A     = mcand;
        alu_B     = DATA_W'(1);
        alu_Op    = OP_SHL;
        state_nxt = ADD;
      end
      DONE: state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      lost    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
      zero    <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            count  <= '0;
            lost   <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        ADD: begin
          if (mplier[0]) begin
            acc <= alu_Out;
            ovf <= ovf | alu_Ofl | lost;
          end
          // Result latched on the final add so it is already valid while done is high.
          if (count == LAST) begin
            product <= mplier[0] ? alu_Out : acc;
            zero    <= mplier[0] ? (alu_Out == '0) : (acc == '0);
          end
        end
        SHL: begin
          mcand  <= alu_Out;
          lost   <= lost | mcand[DATA_W-1];
          mplier <= mplier >> 1;
          count  <= count + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle 16-bit unsigned multiplier. It is the initiator on the ALU operand/opcode interface: it drives A, B, Cin, Op, invA, invB and sign into an external combinational alu instance, and consumes Out, Ofl and Z. It uses ALU add (Op 100) for partial-product accumulation and ALU shift-left (Op 001) for multiplicand shifting. It produces the low 16 bits of the product, an unsigned-overflow flag and a zero flag, under a start/done handshake.

Parameters:
DATA_W, 16, operand/result width; fixed to match the ALU; the only supported value is 16.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a_in  input  16  multiplicand, captured on accepted start
b_in  input  16  multiplier, captured on accepted start
busy  output  1  high in ADD/SHL states
done  output  1  one-cycle pulse; product/ovf/zero valid
product  output  16  low 16 bits of a_in*b_in; held until next accepted start
ovf  output  1  1 iff full 32-bit product >= 2^16
zero  output  1  product == 0
alu_A  output  16  to alu A
alu_B  output  16  to alu B
alu_Cin  output  1  to alu Cin; always 0
alu_Op  output  3  to alu Op
alu_invA  output  1  always 0
alu_invB  output  1  always 0
alu_sign  output  1  always 0 (unsigned; Ofl = carry-out)
alu_Out  input  16  alu result, same-cycle combinational
alu_Ofl  input  1  alu overflow/carry-out
alu_Z  input  1  alu zero; unused

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, product=0, ovf=0, zero=1; internal acc, mcand, mplier=0, count=0, lost=0.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, ADD, SHL, DONE.
- Start acceptance: start=1 in IDLE or DONE loads mcand<=a_in, mplier<=b_in, acc<=0, count<=0, lost<=0, ovf<=0, and moves to ADD. start while busy is ignored.
- ADD:
  - Drive alu_A=acc, alu_B=mcand, alu_Op=100.
  - If mplier[0]=1: acc<=alu_Out; ovf<=ovf|alu_Ofl|lost.
  - If mplier[0]=0: acc unchanged.
  - If count==15, go to DONE; else go to SHL.
- SHL:
  - Drive alu_A=mcand, alu_B=16'h0001, alu_Op=001.
  - mcand<=alu_Out; lost<=lost|mcand[15] (pre-shift value).
  - mplier<=mplier>>1 (internal logic, zero fill); count<=count+1; go to ADD.
- DONE:
  - product<=acc and zero<=(acc==0), registered on entry so they are valid when done=1.
  - done=1 for exactly this one cycle.
  - Next state: ADD if start=1, else IDLE.
- ALU drive in IDLE/DONE: alu_A=0, alu_B=0, alu_Op=100.
- Latency: fixed. Start sampled at edge t; 16 ADD and 15 SHL cycles follow; done is high in cycle t+32. There is no early termination.
- Back-to-back operation: start held high during DONE begins the next operation with zero idle cycles.
- Output retention: product, ovf and zero hold their values through IDLE until the next DONE. ovf is cleared when a new start is accepted.
- Arithmetic: all ALU traffic is unsigned. Overflow is detected when any accumulate add carries out, or when a set multiplier bit meets a multiplicand that has already shifted bits out.

Test Plan:
- a_in=3, b_in=5, start pulse -> done exactly 32 cycles later; product=0x000F, ovf=0, zero=0; busy high for 31 cycles.
- a_in=0xFFFF, b_in=0x0001 -> product=0xFFFF, ovf=0; a_in=0x1234, b_in=0 -> product=0, zero=1, ovf=0.
- a_in=0x0100, b_in=0x0100 -> product=0x0000, ovf=1, zero=1 (lost-bit path). a_in=0xFFFF, b_in=0xFFFF -> product=0x0001, ovf=1. a_in=0x8000, b_in=0x0002 -> product=0, ovf=1.
- Pulse start again while busy with different operands -> ignored; first result unchanged. Start held high through DONE -> second operation's done arrives 32 cycles after the first done.
- Drop rst_n at cycle 10 of an operation -> all outputs return to reset values asynchronously; no done. After release, a fresh 7*9 operation -> product=63.
- ALU interface check every cycle: alu_Cin, alu_invA, alu_invB and alu_sign stay 0; alu_Op alternates 100/001 in ADD/SHL; alu_B=1 in SHL.
